fifo_wr_arbiter: RTL and testbench

Write-side arbiter that shares the single write port of the team's asynchronous FIFO among NREQ requesters in the wr_clk domain. It grants the port round-robin, holds a grant for a bounded burst, and stalls on the FIFO's full flag. It forwards the granted requester's data and a write strobe to the FIFO, and sits between the producer blocks and the FIFO write interface.

---
 rtl/fifo_arb_pkg.sv | 29 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: types, constants and helpers shared by the FIFO write-side arbiter.
package fifo_arb_pkg;

    // Arbiter states: IDLE picks a winner, XFER moves beats for the granted requester.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_t;

    // Default maximum number of beats a requester may move per grant.
    localparam int ARB_DEFAULT_BURST = 4;

    // Ceiling log2, never less than 1 so a counter or index always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Starting at i_start and wrapping past
// NREQ-1 back to 0, it returns the first requester whose bit is set in i_req.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_start,
    output logic [IDXW-1:0] o_idx,
    output logic            o_found
);

    int              w_sum;
    logic [IDXW-1:0] w_cand;

    // Walk the requesters in priority order from i_start; the first set bit wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_sum   = 0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = int'(i_start) + k;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_cand = IDXW'(w_sum);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the single write port of the asynchronous FIFO among NREQ
// producers in the wr_clk domain. Grants are handed out round-robin, each grant lasts
// at most BURST beats, and the FIFO full flag back-pressures the granted producer.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  NREQ  = 4,
    parameter int  BURST = ARB_DEFAULT_BURST,
    localparam int IDXW  = clog2(NREQ),
    localparam int CNTW  = clog2(BURST + 1)
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [WIDTH-1:0]      fifo_wr_data,
    output logic                  grant_vld,
    output logic [IDXW-1:0]       grant_idx
);

    arb_state_t       r_state;
    logic [IDXW-1:0]  r_grantIdx;
    logic [IDXW-1:0]  r_lastIdx;
    logic [CNTW-1:0]  r_beatCnt;

    arb_state_t       w_stateNxt;
    logic [IDXW-1:0]  w_grantNxt;
    logic [IDXW-1:0]  w_lastNxt;
    logic [CNTW-1:0]  w_cntNxt;

    logic [IDXW-1:0]  w_start;
    logic [IDXW-1:0]  w_winner;
    logic             w_found;

    logic [WIDTH-1:0] w_slice [NREQ];
    logic             w_grantValid;
    logic [WIDTH-1:0] w_grantData;
    logic [CNTW-1:0]  w_cntInc;

    logic             w_wrEn;
    logic [WIDTH-1:0] w_wrData;
    logic [NREQ-1:0]  w_ready;

    // Split the flat data bus into one lane per requester for indexed selection.
    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign w_slice[i] = req_data[i*WIDTH +: WIDTH];
    end

    assign w_grantValid = req_valid[r_grantIdx];
    assign w_grantData  = w_slice[r_grantIdx];
    assign w_cntInc     = r_beatCnt + 1'b1;

    // The search begins one past the last winner, wrapping after requester NREQ-1.
    always_comb begin
        if (r_lastIdx == IDXW'(NREQ - 1)) begin
            w_start = '0;
        end else begin
            w_start = r_lastIdx + 1'b1;
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rrPick (
        .i_req   (req_valid),
        .i_start (w_start),
        .o_idx   (w_winner),
        .o_found (w_found)
    );

    // State register; reset parks last_idx on NREQ-1 so requester 0 is searched first.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_state    <= ARB_IDLE;
            r_grantIdx <= '0;
            r_lastIdx  <= IDXW'(NREQ - 1);
            r_beatCnt  <= '0;
        end else begin
            r_state    <= w_stateNxt;
            r_grantIdx <= w_grantNxt;
            r_lastIdx  <= w_lastNxt;
            r_beatCnt  <= w_cntNxt;
        end
    end

    // Next-state decision: grant in IDLE; in XFER count beats, hold on stall, release on drop or full burst.
    always_comb begin
        w_stateNxt = r_state;
        w_grantNxt = r_grantIdx;
        w_lastNxt  = r_lastIdx;
        w_cntNxt   = r_beatCnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_stateNxt = ARB_XFER;
                    w_grantNxt = w_winner;
                    w_lastNxt  = w_winner;
                    w_cntNxt   = '0;
                end
            end
            ARB_XFER: begin
                if (w_wrEn) begin
                    w_cntNxt = w_cntInc;
                    if (w_cntInc == CNTW'(BURST)) begin
                        w_stateNxt = ARB_IDLE;
                    end
                end else if (!w_grantValid) begin
                    w_stateNxt = ARB_IDLE;
                end
            end
            default: begin
                w_stateNxt = ARB_IDLE;
            end
        endcase
    end

    // Outputs: only XFER touches the FIFO; fifo_full blocks the write in the same cycle and data idles at zero.
    always_comb begin
        w_wrEn   = 1'b0;
        w_wrData = '0;
        w_ready  = '0;
        if (r_state == ARB_XFER) begin
            w_wrEn = w_grantValid & ~fifo_full;
            if (!fifo_full) begin
                w_ready[r_grantIdx] = 1'b1;
            end
            if (w_wrEn) begin
                w_wrData = w_grantData;
            end
        end
    end

    assign fifo_wr_en   = w_wrEn;
    assign fifo_wr_data = w_wrData;
    assign req_ready    = w_ready;
    assign grant_vld    = (r_state == ARB_XFER);
    assign grant_idx    = r_grantIdx;

    // Structural invariants: at most one ready, no write into a full FIFO, bounded burst count.
    always_ff @(posedge wr_clk) begin
        if (!reset) begin
            assert ($onehot0(req_ready))
                else $error("req_ready not one-hot-or-zero");
            assert (!(fifo_wr_en && fifo_full))
                else $error("write issued while FIFO full");
            assert (r_beatCnt <= CNTW'(BURST))
                else $error("beat count beyond burst limit");
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized and directed bench for fifo_wr_arbiter, checked
// against a transaction-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int NREQ_A  = 4;
    localparam int BURST_A = 4;

    logic        wr_clk;
    logic        reset;

    // Main instance: NREQ=4, BURST=4
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        grant_vld;
    logic [1:0]  grant_idx;

    // Second instance: NREQ=2, BURST=1
    logic [1:0]  bValid;
    logic [15:0] bData;
    logic [1:0]  bReady;
    logic        bFull;
    logic        bWrEn;
    logic [7:0]  bWrData;
    logic        bGrantVld;
    logic [0:0]  bGrantIdx;

    int nAsserts;
    int nFails;

    // Reference model: who holds the port, how many beats moved, who won last
    bit         mBusy;
    int         mOwner;
    int         mBeats;
    int         mLast;
    logic [7:0] srcData [4];

    logic       expWrEn;
    logic [7:0] expWrData;
    logic [3:0] expReady;
    logic       expGrantVld;
    logic [1:0] expGrantIdx;

    fifo_wr_arbiter #(.WIDTH(8), .NREQ(NREQ_A), .BURST(BURST_A)) dutA (
        .wr_clk       (wr_clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_vld    (grant_vld),
        .grant_idx    (grant_idx)
    );

    fifo_wr_arbiter #(.WIDTH(8), .NREQ(2), .BURST(1)) dutB (
        .wr_clk       (wr_clk),
        .reset        (reset),
        .req_valid    (bValid),
        .req_data     (bData),
        .req_ready    (bReady),
        .fifo_full    (bFull),
        .fifo_wr_en   (bWrEn),
        .fifo_wr_data (bWrData),
        .grant_vld    (bGrantVld),
        .grant_idx    (bGrantIdx)
    );

    // Free-running write clock, period 10
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got still running want finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void modelReset();
        mBusy  = 1'b0;
        mOwner = 0;
        mBeats = 0;
        mLast  = NREQ_A - 1;
    endfunction

    // Expected outputs for this cycle, then the decision taken at the coming edge
    function automatic void modelStep(input logic [3:0] v, input logic f);
        bit found;
        int cand;
        expGrantIdx = 2'(mOwner);
        expGrantVld = mBusy;
        expWrEn     = 1'b0;
        expWrData   = 8'h00;
        expReady    = 4'b0000;
        if (!mBusy) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ_A; k++) begin
                cand = (mLast + k) % NREQ_A;
                if (!found && v[2'(cand)]) begin
                    found  = 1'b1;
                    mOwner = cand;
                    mLast  = cand;
                    mBeats = 0;
                    mBusy  = 1'b1;
                end
            end
        end else begin
            expReady  = f ? 4'b0000 : 4'(1 << mOwner);
            expWrEn   = v[2'(mOwner)] & ~f;
            expWrData = expWrEn ? srcData[mOwner] : 8'h00;
            if (expWrEn) begin
                srcData[mOwner] = srcData[mOwner] + 8'h01;
                mBeats = mBeats + 1;
                if (mBeats == BURST_A) begin
                    mBusy = 1'b0;
                end
            end else if (!v[2'(mOwner)]) begin
                mBusy = 1'b0;
            end
        end
    endfunction

    function automatic logic [15:0] packGot();
        return {grant_vld, grant_idx, fifo_wr_en, fifo_wr_data, req_ready};
    endfunction

    function automatic logic [15:0] packExp();
        return {expGrantVld, expGrantIdx, expWrEn, expWrData, expReady};
    endfunction

    // Drive one cycle on the main instance away from the rising edge and advance the model
    task automatic applyStimulus(input logic [3:0] v, input logic f);
        @(negedge wr_clk);
        req_valid = v;
        fifo_full = f;
        req_data  = {srcData[3], srcData[2], srcData[1], srcData[0]};
        #1;
        modelStep(v, f);
    endtask

    task automatic doReset();
        reset     = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        bValid    = '0;
        bFull     = 1'b0;
        repeat (2) @(negedge wr_clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        nAsserts++;
        if (packGot() !== 16'h0000) begin
            nFails++;
            $display("[TB] FAIL reset_a: got %h want 0000", packGot());
        end
        nAsserts++;
        if ({bGrantVld, bGrantIdx, bWrEn, bWrData, bReady} !== 13'h0) begin
            nFails++;
            $display("[TB] FAIL reset_b: got %h want 0", {bGrantVld, bGrantIdx, bWrEn, bWrData, bReady});
        end
        @(negedge wr_clk);
        nAsserts++;
        if (packGot() !== 16'h0000) begin
            nFails++;
            $display("[TB] FAIL reset_held: got %h want 0000", packGot());
        end
        reset = 1'b0;
        modelReset();
        applyStimulus(4'b0000, 1'b0);
        nAsserts++;
        if (packGot() !== packExp()) begin
            nFails++;
            $display("[TB] FAIL reset_idle: got %h want %h", packGot(), packExp());
        end
    endtask

    task automatic test_single_requester();
        logic [7:0] writes [$];
        logic [7:0] pattern;
        logic [7:0] want;
        doReset();
        srcData[0] = 8'h0A;
        pattern = '0;
        for (int c = 0; c < 9; c++) begin
            applyStimulus((srcData[0] <= 8'h0F) ? 4'b0001 : 4'b0000, 1'b0);
            nAsserts++;
            if (packGot() !== packExp()) begin
                nFails++;
                $display("[TB] FAIL single_model c%0d: got %h want %h", c, packGot(), packExp());
            end
            if (c < 8) pattern[c] = fifo_wr_en;
            if (fifo_wr_en === 1'b1) writes.push_back(fifo_wr_data);
            if (c == 1) begin
                nAsserts++;
                if ({grant_vld, grant_idx} !== 3'b100) begin
                    nFails++;
                    $display("[TB] FAIL single_grant: got vld=%0b idx=%0d want vld=1 idx=0", grant_vld, grant_idx);
                end
            end
        end
        nAsserts++;
        if (pattern !== 8'hDE) begin
            nFails++;
            $display("[TB] FAIL single_pattern: got %b want 11011110", pattern);
        end
        nAsserts++;
        if (writes.size() != 6) begin
            nFails++;
            $display("[TB] FAIL single_count: got %0d want 6", writes.size());
        end
        for (int i = 0; i < writes.size() && i < 6; i++) begin
            want = 8'h0A + 8'(i);
            nAsserts++;
            if (writes[i] !== want) begin
                nFails++;
                $display("[TB] FAIL single_data[%0d]: got %h want %h", i, writes[i], want);
            end
        end
    endtask

    task automatic test_all_requesters();
        int  wantOrder [5] = '{0, 1, 2, 3, 0};
        int  grants [$];
        int  run;
        int  maxRun;
        int  nWrites;
        logic prevVld;
        doReset();
        for (int i = 0; i < 4; i++) srcData[i] = 8'($urandom_range(0, 255));
        run = 0; maxRun = 0; nWrites = 0; prevVld = 1'b0;
        for (int c = 0; c < 25; c++) begin
            applyStimulus(4'b1111, 1'b0);
            nAsserts++;
            if (packGot() !== packExp()) begin
                nFails++;
                $display("[TB] FAIL all_model c%0d: got %h want %h", c, packGot(), packExp());
            end
            if (grant_vld === 1'b1 && prevVld !== 1'b1) grants.push_back(int'(grant_idx));
            prevVld = grant_vld;
            if (fifo_wr_en === 1'b1) begin
                run++;
                nWrites++;
            end else begin
                run = 0;
            end
            if (run > maxRun) maxRun = run;
        end
        nAsserts++;
        if (grants.size() != 5) begin
            nFails++;
            $display("[TB] FAIL all_grant_count: got %0d want 5", grants.size());
        end
        for (int i = 0; i < grants.size() && i < 5; i++) begin
            nAsserts++;
            if (grants[i] != wantOrder[i]) begin
                nFails++;
                $display("[TB] FAIL all_order[%0d]: got %0d want %0d", i, grants[i], wantOrder[i]);
            end
        end
        nAsserts++;
        if (maxRun != BURST_A || nWrites != 20) begin
            nFails++;
            $display("[TB] FAIL all_burst: got run=%0d writes=%0d want run=4 writes=20", maxRun, nWrites);
        end
    endtask

    task automatic test_stall();
        int  nWrites;
        logic f;
        doReset();
        srcData[2] = 8'($urandom_range(0, 255));
        nWrites = 0;
        for (int c = 0; c < 8; c++) begin
            f = (c >= 3 && c <= 5);
            applyStimulus(4'b0100, f);
            nAsserts++;
            if (packGot() !== packExp()) begin
                nFails++;
                $display("[TB] FAIL stall_model c%0d: got %h want %h", c, packGot(), packExp());
            end
            if (fifo_wr_en === 1'b1) nWrites++;
            if (f) begin
                nAsserts++;
                if ({grant_vld, grant_idx, fifo_wr_en, req_ready, dutA.r_beatCnt} !== {1'b1, 2'd2, 1'b0, 4'b0000, 3'd2}) begin
                    nFails++;
                    $display("[TB] FAIL stall_hold c%0d: got vld=%0b idx=%0d wr=%0b rdy=%b cnt=%0d want vld=1 idx=2 wr=0 rdy=0000 cnt=2",
                             c, grant_vld, grant_idx, fifo_wr_en, req_ready, dutA.r_beatCnt);
                end
            end
        end
        nAsserts++;
        if (nWrites != 4) begin
            nFails++;
            $display("[TB] FAIL stall_writes: got %0d want 4", nWrites);
        end
    endtask

    task automatic test_drop();
        logic [3:0] seq [5] = '{4'b1010, 4'b1010, 4'b1000, 4'b1010, 4'b1010};
        doReset();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(seq[c], 1'b0);
            nAsserts++;
            if (packGot() !== packExp()) begin
                nFails++;
                $display("[TB] FAIL drop_model c%0d: got %h want %h", c, packGot(), packExp());
            end
            if (c == 1 || c == 4) begin
                nAsserts++;
                if ({grant_vld, grant_idx} !== ((c == 1) ? 3'b101 : 3'b111)) begin
                    nFails++;
                    $display("[TB] FAIL drop_grant c%0d: got vld=%0b idx=%0d want idx=%0d", c, grant_vld, grant_idx, (c == 1) ? 1 : 3);
                end
            end
            if (c == 3) begin
                nAsserts++;
                if ({grant_vld, fifo_wr_en} !== 2'b00) begin
                    nFails++;
                    $display("[TB] FAIL drop_idle: got vld=%0b wr=%0b want 0 0", grant_vld, fifo_wr_en);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        doReset();
        srcData[3] = 8'h30;
        srcData[0] = 8'h50;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b1000, 1'b0);
            nAsserts++;
            if (packGot() !== packExp()) begin
                nFails++;
                $display("[TB] FAIL rmid_model c%0d: got %h want %h", c, packGot(), packExp());
            end
        end
        #1;
        reset     = 1'b1;
        req_valid = 4'b1001;
        #1;
        nAsserts++;
        if (packGot() !== 16'h0000) begin
            nFails++;
            $display("[TB] FAIL rmid_async: got %h want 0000", packGot());
        end
        #1;
        reset = 1'b0;
        modelReset();
        modelStep(4'b1001, 1'b0);
        nAsserts++;
        if (packGot() !== packExp()) begin
            nFails++;
            $display("[TB] FAIL rmid_release: got %h want %h", packGot(), packExp());
        end
        applyStimulus(4'b1001, 1'b0);
        nAsserts++;
        if ({grant_vld, grant_idx, fifo_wr_en, fifo_wr_data} !== {1'b1, 2'd0, 1'b1, 8'h50}) begin
            nFails++;
            $display("[TB] FAIL rmid_regrant: got vld=%0b idx=%0d wr=%0b data=%h want vld=1 idx=0 wr=1 data=50",
                     grant_vld, grant_idx, fifo_wr_en, fifo_wr_data);
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        logic       f;
        doReset();
        for (int i = 0; i < 4; i++) srcData[i] = 8'($urandom_range(0, 255));
        v = 4'($urandom_range(0, 15));
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) v = 4'($urandom_range(0, 15));
            f = ($urandom_range(0, 4) == 0);
            applyStimulus(v, f);
            nAsserts++;
            if (packGot() !== packExp()) begin
                nFails++;
                $display("[TB] FAIL random_model c%0d: got %h want %h", c, packGot(), packExp());
            end
        end
    endtask

    task automatic test_two_requesters();
        logic       eVld;
        logic [0:0] eIdx;
        logic       eWr;
        logic [7:0] eData;
        logic [1:0] eRdy;
        int         g;
        doReset();
        for (int c = 0; c < 8; c++) begin
            @(negedge wr_clk);
            bValid = 2'b11;
            bData  = 16'hB1A0;
            bFull  = 1'b0;
            #1;
            if (c % 2 == 0) begin
                eVld  = 1'b0;
                eWr   = 1'b0;
                eData = 8'h00;
                eRdy  = 2'b00;
                eIdx  = (c == 0) ? 1'b0 : 1'(((c - 2) / 2) % 2);
            end else begin
                g     = ((c - 1) / 2) % 2;
                eVld  = 1'b1;
                eIdx  = 1'(g);
                eWr   = 1'b1;
                eData = (g == 1) ? 8'hB1 : 8'hA0;
                eRdy  = (g == 1) ? 2'b10 : 2'b01;
            end
            nAsserts++;
            if ({bGrantVld, bGrantIdx, bWrEn, bWrData, bReady} !== {eVld, eIdx, eWr, eData, eRdy}) begin
                nFails++;
                $display("[TB] FAIL two_req c%0d: got %h want %h", c,
                         {bGrantVld, bGrantIdx, bWrEn, bWrData, bReady}, {eVld, eIdx, eWr, eData, eRdy});
            end
        end
        @(negedge wr_clk);
        bValid = 2'b00;
    endtask

    initial begin
        nAsserts  = 0;
        nFails    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        bValid    = '0;
        bData     = '0;
        bFull     = 1'b0;
        for (int i = 0; i < 4; i++) srcData[i] = 8'h00;
        modelReset();

        test_reset();
        test_single_requester();
        test_all_requesters();
        test_stall();
        test_drop();
        test_reset_mid_burst();
        test_random();
        test_two_requesters();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
